// File: rtl/inst_rom_if.sv
// Fetch port and boot-loader byte stream of the instruction ROM.
// The core/loader side is the master; the ROM is the slave.
interface inst_rom_if;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] inst_o;
   logic        load_valid_i;
   logic [7:0]  load_data_i;
   logic        load_last_i;
   logic        load_ready_o;

   modport master (
      output ce, addr, load_valid_i, load_data_i, load_last_i,
      input  inst_o, load_ready_o
   );

   modport slave (
      input  ce, addr, load_valid_i, load_data_i, load_last_i,
      output inst_o, load_ready_o
   );
endinterface

// File: rtl/inst_rom.sv
// Instruction memory for the Sirius fetch port with a byte-serial boot loader.
// After reset the loader fills the memory big-endian while the core is held in
// reset; the final byte releases the core. Fetch reads are combinational.
module inst_rom #(
   parameter int DEPTH_LOG2 = 10,
   parameter bit BOOT_LOAD  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   inst_rom_if.slave           bus,
   input  logic                load_start_i,
   output logic                core_rst_o,
   output logic                load_err_o,
   output logic [DEPTH_LOG2:0] loaded_words_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam state_t RESET_STATE = (BOOT_LOAD == 1'b1) ? ST_LOAD : ST_RUN;

   logic [31:0]           mem_r [DEPTH];
   state_t                state_r;
   state_t                state_nxt_s;
   logic [DEPTH_LOG2:0]   wr_ptr_r;
   logic [1:0]            byte_cnt_r;
   logic [23:0]           stage_r;
   logic                  err_r;
   logic                  ready_s;
   logic                  accept_s;
   logic                  word_due_s;
   logic                  full_s;
   logic                  wr_en_s;
   logic [31:0]           word_s;
   logic [DEPTH_LOG2-1:0] rd_idx_s;

   // Loader handshake, write decision and big-endian word assembly.
   always_comb begin
      ready_s    = (state_r == ST_LOAD) && !rst;
      accept_s   = bus.load_valid_i && ready_s;
      word_due_s = accept_s && ((byte_cnt_r == 2'd3) || bus.load_last_i);
      // wr_ptr never exceeds DEPTH, so its top bit alone means "memory full".
      full_s     = wr_ptr_r[DEPTH_LOG2];
      wr_en_s    = word_due_s && !full_s;
      case (byte_cnt_r)
         2'd0:    word_s = {bus.load_data_i, 24'h000000};
         2'd1:    word_s = {stage_r[23:16], bus.load_data_i, 16'h0000};
         2'd2:    word_s = {stage_r[23:8], bus.load_data_i, 8'h00};
         2'd3:    word_s = {stage_r, bus.load_data_i};
         default: word_s = 32'h00000000;
      endcase
   end

   // Next-state logic: final byte releases the core, load_start re-enters LOAD.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_LOAD: begin
            if (accept_s && bus.load_last_i) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (load_start_i) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: state_nxt_s = RESET_STATE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= RESET_STATE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Loader bookkeeping: byte counter, staging bytes, write pointer, overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         byte_cnt_r <= 2'd0;
         stage_r    <= 24'h000000;
         err_r      <= 1'b0;
      end else if ((state_r == ST_RUN) && load_start_i) begin
         wr_ptr_r   <= '0;
         byte_cnt_r <= 2'd0;
         stage_r    <= 24'h000000;
         err_r      <= 1'b0;
      end else if (accept_s) begin
         if (word_due_s) begin
            byte_cnt_r <= 2'd0;
            stage_r    <= 24'h000000;
            if (full_s) begin
               err_r <= 1'b1;
            end else begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
         end else begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
               2'd0:    stage_r[23:16] <= bus.load_data_i;
               2'd1:    stage_r[15:8]  <= bus.load_data_i;
               default: stage_r[7:0]   <= bus.load_data_i;
            endcase
         end
      end
   end

   // Memory write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= word_s;
      end
   end

   // Zero-latency fetch; the index wraps modulo the memory size.
   always_comb begin
      rd_idx_s = bus.addr[DEPTH_LOG2+1:2];
      if (bus.ce && !rst && (state_r == ST_RUN)) begin
         bus.inst_o = mem_r[rd_idx_s];
      end else begin
         bus.inst_o = 32'h00000000;
      end
   end

   assign bus.load_ready_o  = ready_s;
   assign core_rst_o        = rst | (state_r != ST_RUN);
   assign load_err_o        = err_r;
   assign loaded_words_o    = wr_ptr_r;

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: a default-depth instance and a 4-word instance.
// Fetch expectations come from a bench memory model pushed into a scoreboard
// queue when the address is driven and popped when inst_o is sampled.
module tb_inst_rom;
   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic        load_start_s;
   logic        core_rst;
   logic        core_rst_s;
   logic        load_err;
   logic        load_err_s;
   logic [10:0] words;
   logic [2:0]  words_s;

   int total = 0;
   int bad   = 0;
   logic [31:0] word_q[$];
   logic [31:0] mdl   [1024];
   logic [31:0] mdl_s [4];

   inst_rom_if bus();
   inst_rom_if bus_s();

   inst_rom #(.DEPTH_LOG2(10), .BOOT_LOAD(1'b1)) dut (
      .clk(clk), .rst(rst), .bus(bus), .load_start_i(load_start),
      .core_rst_o(core_rst), .load_err_o(load_err), .loaded_words_o(words)
   );

   inst_rom #(.DEPTH_LOG2(2), .BOOT_LOAD(1'b1)) dut_s (
      .clk(clk), .rst(rst), .bus(bus_s), .load_start_i(load_start_s),
      .core_rst_o(core_rst_s), .load_err_o(load_err_s), .loaded_words_o(words_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_byte(input bit sel, input logic [7:0] d, input logic last);
      if (sel) begin
         bus_s.load_valid_i = 1'b1; bus_s.load_data_i = d; bus_s.load_last_i = last;
      end else begin
         bus.load_valid_i = 1'b1; bus.load_data_i = d; bus.load_last_i = last;
      end
      next_cycle();
      bus.load_valid_i = 1'b0;   bus.load_last_i = 1'b0;
      bus_s.load_valid_i = 1'b0; bus_s.load_last_i = 1'b0;
   endtask

   // Sends an image (last flag on its final byte) and updates the memory model.
   task automatic send_image(input bit sel, input logic [7:0] img[$]);
      logic [31:0] cur;
      int n;
      int wp;
      int cap;
      cur = 32'h0; n = 0; wp = 0;
      cap = sel ? 4 : 1024;
      foreach (img[i]) begin
         logic last;
         last = (i == img.size() - 1);
         cur = cur | ({24'h000000, img[i]} << (24 - 8 * n));
         n++;
         if (n == 4 || last) begin
            if (wp < cap) begin
               if (sel) mdl_s[wp] = cur;
               else     mdl[wp]   = cur;
               wp++;
            end
            cur = 32'h0;
            n = 0;
         end
         drive_byte(sel, img[i], last);
      end
   endtask

   task automatic read_word(input bit sel, input logic [31:0] a, input string tag);
      logic [31:0] obs;
      next_cycle();
      if (sel) begin
         bus_s.ce = 1'b1; bus_s.addr = a; word_q.push_back(mdl_s[a[3:2]]);
      end else begin
         bus.ce = 1'b1; bus.addr = a; word_q.push_back(mdl[a[11:2]]);
      end
      #2;
      obs = sel ? bus_s.inst_o : bus.inst_o;
      chk(tag, obs, word_q.pop_front());
   endtask

   initial begin
      logic [7:0] img[$];
      rst = 1'b1; load_start = 1'b0; load_start_s = 1'b0;
      bus.ce = 1'b1;   bus.addr = 32'h0;   bus.load_valid_i = 1'b0;
      bus.load_data_i = 8'h00;   bus.load_last_i = 1'b0;
      bus_s.ce = 1'b0; bus_s.addr = 32'h0; bus_s.load_valid_i = 1'b0;
      bus_s.load_data_i = 8'h00; bus_s.load_last_i = 1'b0;

      // Reset values
      next_cycle();
      next_cycle();
      chk("rst_core_rst", 32'(core_rst), 32'h1);
      chk("rst_ready", 32'(bus.load_ready_o), 32'h0);
      chk("rst_inst", bus.inst_o, 32'h0);
      chk("rst_words", 32'(words), 32'h0);
      chk("rst_err", 32'(load_err), 32'h0);
      rst = 1'b0;
      bus.ce = 1'b0;
      #1;
      chk("load_ready", 32'(bus.load_ready_o), 32'h1);
      chk("load_core_rst", 32'(core_rst), 32'h1);

      // Boot image of two full words
      img = {8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h00, 8'h05};
      send_image(1'b0, img);
      chk("boot_core_rst", 32'(core_rst), 32'h0);
      chk("boot_ready", 32'(bus.load_ready_o), 32'h0);
      chk("boot_words", 32'(words), 32'h2);
      chk("boot_err", 32'(load_err), 32'h0);
      read_word(1'b0, 32'h4, "fetch_a4");
      chk("fetch_a4_const", bus.inst_o, 32'h34210005);
      read_word(1'b0, 32'h0, "fetch_a0");
      read_word(1'b0, 32'h1004, "fetch_wrap");

      // Reload with a short final word
      next_cycle();
      load_start = 1'b1;
      next_cycle();
      load_start = 1'b0;
      bus.ce = 1'b1; bus.addr = 32'h0;
      #1;
      chk("start_core_rst", 32'(core_rst), 32'h1);
      chk("start_ready", 32'(bus.load_ready_o), 32'h1);
      chk("start_inst", bus.inst_o, 32'h0);
      chk("start_words", 32'(words), 32'h0);
      img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      send_image(1'b0, img);
      chk("short_words", 32'(words), 32'h2);
      read_word(1'b0, 32'h4, "short_a4");
      chk("short_a4_const", bus.inst_o, 32'hEEFF0000);
      read_word(1'b0, 32'h0, "short_a0");

      // Reset in the middle of a word
      next_cycle();
      load_start = 1'b1;
      next_cycle();
      load_start = 1'b0;
      drive_byte(1'b0, 8'h55, 1'b0);
      drive_byte(1'b0, 8'h66, 1'b0);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1;
      chk("midrst_words", 32'(words), 32'h0);
      chk("midrst_core_rst", 32'(core_rst), 32'h1);
      img = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_image(1'b0, img);
      chk("midrst_words_after", 32'(words), 32'h1);
      read_word(1'b0, 32'h0, "midrst_a0");
      read_word(1'b0, 32'h4, "midrst_keep_a4");

      // Reload request while fetching
      next_cycle();
      load_start = 1'b1;
      bus.ce = 1'b1; bus.addr = 32'h0;
      next_cycle();
      load_start = 1'b0;
      chk("reload_core_rst", 32'(core_rst), 32'h1);
      chk("reload_inst", bus.inst_o, 32'h0);
      img = {8'h11, 8'h22, 8'h33, 8'h44};
      send_image(1'b0, img);
      read_word(1'b0, 32'h0, "reload_a0");

      // ce low, and stray loader bytes in RUN
      bus.ce = 1'b0; bus.addr = 32'h0;
      #1;
      chk("ce_low_inst", bus.inst_o, 32'h0);
      drive_byte(1'b0, 8'h99, 1'b1);
      drive_byte(1'b0, 8'h77, 1'b0);
      chk("run_ignore_words", 32'(words), 32'h1);
      chk("run_ignore_core_rst", 32'(core_rst), 32'h0);
      read_word(1'b0, 32'h0, "run_ignore_a0");

      // Overflow on the 4-word instance (it is in LOAD since the last reset)
      img = {};
      for (int i = 1; i <= 20; i++) img.push_back(8'(i));
      send_image(1'b1, img);
      chk("ovf_err", 32'(load_err_s), 32'h1);
      chk("ovf_words", 32'(words_s), 32'h4);
      chk("ovf_core_rst", 32'(core_rst_s), 32'h0);
      read_word(1'b1, 32'h10, "ovf_wrap_a10");
      chk("ovf_wrap_const", bus_s.inst_o, 32'h01020304);
      read_word(1'b1, 32'hC, "ovf_a0c");
      next_cycle();
      load_start_s = 1'b1;
      next_cycle();
      load_start_s = 1'b0;
      chk("ovf_err_clear", 32'(load_err_s), 32'h0);
      chk("ovf_restart_words", 32'(words_s), 32'h0);
      chk("ovf_restart_core_rst", 32'(core_rst_s), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction memory responder for the Sirius core's fetch port: it answers `rom_ce`/`rom_addr` with the 32-bit instruction word in the same cycle. It also owns a byte-serial boot loader that fills the memory after reset while holding the core in reset, then releases the core. It sits beside `Sirius` at SoC top level: core `rom_addr_o`/`rom_ce_o` connect to this block, and its `inst_o` drives core `rom_data_i`.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: log2 of memory depth in 32-bit words (1024 words).
- `BOOT_LOAD`, default 1: 1 = enter LOAD after reset; 0 = enter RUN directly (memory preloaded by the simulation environment).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  fetch enable from core `rom_ce_o`.
- `addr`  in  32  fetch byte address from core `rom_addr_o`.
- `inst_o`  out  32  instruction word to core `rom_data_i`.
- `load_valid_i`  in  1  loader byte valid.
- `load_data_i`  in  8  loader byte.
- `load_last_i`  in  1  marks the final byte of an image; qualified by `load_valid_i`.
- `load_ready_o`  out  1  loader may transfer a byte this cycle.
- `load_start_i`  in  1  single-cycle request to reload while in RUN.
- `core_rst_o`  out  1  reset to the core's `rst`.
- `load_err_o`  out  1  sticky overflow flag.
- `loaded_words_o`  out  `DEPTH_LOG2+1`  number of words written in the current or last load.

## Operation
- Storage: `2**DEPTH_LOG2` x 32-bit array. Memory contents are never cleared by `rst`.
- Fetch read is combinational. Word index = `addr[DEPTH_LOG2+1:2]`; `addr[1:0]` and the upper bits are ignored, so addresses wrap modulo the memory size.
- `inst_o` = 0 when `ce`=0, when `rst`=1, or when the state is not RUN. Otherwise `inst_o` = mem[index].
- States: LOAD and RUN. Reset puts the block in LOAD if `BOOT_LOAD`=1, otherwise in RUN.
- `load_ready_o` = 1 exactly in LOAD and while `rst`=0. A byte is accepted when `load_valid_i` & `load_ready_o` are both high.
- Byte assembly is big-endian. The first byte of a word goes to [31:24], then [23:16], [15:8], [7:0]. A 2-bit byte counter and a 24-bit staging register hold the partial word.
- A word is written to mem[wr_ptr] when the 4th byte is accepted, or when an accepted byte has `load_last_i`=1. On a short final word the unfilled low bytes are zero. After each write, wr_ptr increments and the byte counter clears.
- wr_ptr is `DEPTH_LOG2+1` bits wide. `loaded_words_o` = wr_ptr.
- Overflow: if a word write is due while wr_ptr = `2**DEPTH_LOG2`, the write is dropped, wr_ptr holds, and `load_err_o` is set. `load_err_o` stays set until the next entry to LOAD.
- An accepted byte with `load_last_i`=1 moves the state to RUN, including when the final write overflowed.
- In RUN, `load_start_i`=1 moves the state to LOAD and clears wr_ptr, the byte counter, the staging register and `load_err_o`. `load_valid_i` is ignored in RUN.
- `core_rst_o` = `rst` | (state != RUN). It is combinational from `rst` and the state register.

## Timing
- Reset values, after a `rst` edge: state = LOAD (or RUN if `BOOT_LOAD`=0); wr_ptr = 0; byte counter = 0; staging register = 0; `load_err_o` = 0; `loaded_words_o` = 0; `core_rst_o` = 1; `load_ready_o` = 0 while `rst` is high; `inst_o` = 0.
- Fetch latency is 0 cycles: `inst_o` is valid in the same cycle as `addr`. The core's `if_id` captures it on the next edge together with the pc.
- A write completes at the edge on which its last byte is accepted. The new data is readable in the cycle after that edge.
- Final byte accepted at edge N: state = RUN after edge N, so `core_rst_o` = 0 and `load_ready_o` = 0 in cycle N+1. The core's first fetch (pc 0) happens in cycle N+1 or later.
- `load_start_i` sampled at edge M: `core_rst_o` = 1 and `load_ready_o` = 1 in cycle M+1.
- A mid-load `rst` discards any partial word. Words already written remain in memory, and the state returns to LOAD (or RUN if `BOOT_LOAD`=0).
- `load_valid_i` throughput is up to one byte per cycle, with no backpressure inside LOAD.

## Test plan
- Reset, then 8 bytes 3C,01,12,34,34,21,00,05 (last on 05): mem[0]=3C011234, mem[1]=34210005, `loaded_words_o`=2, `core_rst_o` drops the cycle after the 05 byte. Then `ce`=1, `addr`=4 gives `inst_o`=34210005 in the same cycle.
- 6 bytes AA,BB,CC,DD,EE,FF (last on FF): mem[1]=EEFF0000, `loaded_words_o`=2.
- `DEPTH_LOG2`=2, stream 20 bytes (last on the 20th): 4 words written, 5th word dropped, `load_err_o`=1, state RUN, `addr`=0x10 returns mem[0].
- `rst` asserted after 2 bytes of word 1 of a load: `loaded_words_o`=0, mem[0] unchanged, next 4 bytes land in mem[0].
- In RUN, pulse `load_start_i`: `core_rst_o`=1, `load_err_o` cleared, `inst_o`=0 while `ce`=1. A reload of 4 bytes 11,22,33,44 (last on 44) gives mem[0]=11223344.
- `ce`=0 with `addr`=0 in RUN: `inst_o`=0. `load_valid_i` pulses in RUN leave memory and `loaded_words_o` unchanged.
